// File: rtl/hs4_tx.sv
// Clocked initiator for a 4-phase return-to-zero bundled-data channel.
// Optional watchdog compiled in with `define HS4_TX_TIMEOUT_EN.
module hs4_tx #(
   parameter int DATA_W      = 8,
   parameter int SETUP_CYC   = 1,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              hs_req,
   output logic [DATA_W-1:0] hs_data,
   input  logic              hs_ack,
   output logic              busy,
   output logic [7:0]        tx_count,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, SETUP, REQ_UP, REQ_DN} state_t;

   localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYC - 1);
   localparam logic [7:0] WD_LAST    = 8'(TIMEOUT_CYC - 1);

   if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup
      $error("hs4_tx: SETUP_CYC out of range");
   end
   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("hs4_tx: SYNC_STAGES out of range");
   end
   if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_tmo
      $error("hs4_tx: TIMEOUT_CYC out of range");
   end

   state_t                 r_state;
   state_t                 w_next;
   logic [SYNC_STAGES-1:0] r_sync;
   logic [3:0]             r_setup_cnt;
   logic                   w_ack_s;
   logic                   w_accept;
   logic                   w_wd_hit;

   assign w_ack_s  = r_sync[SYNC_STAGES-1];
   assign in_ready = (r_state == IDLE) && !w_ack_s;
   assign w_accept = in_valid && in_ready;
   assign busy     = (r_state != IDLE);

`ifdef HS4_TX_TIMEOUT_EN
   logic [7:0] r_wd;
   logic       r_err;

   assign w_wd_hit = ((r_state == REQ_UP) || (r_state == REQ_DN)) && (r_wd == WD_LAST);
   assign err      = r_err;

   // Watchdog restarts on every entry into a request phase.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wd  <= 8'd0;
         r_err <= 1'b0;
      end else begin
         if ((w_next == REQ_UP || w_next == REQ_DN) && (w_next != r_state))
            r_wd <= 8'd0;
         else if (r_state == REQ_UP || r_state == REQ_DN)
            r_wd <= r_wd + 8'd1;
         if (w_wd_hit)
            r_err <= 1'b1;
      end
   end
`else
   assign w_wd_hit = 1'b0;
   assign err      = 1'b0;
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = SETUP;
         SETUP:   if (r_setup_cnt == 4'd0) w_next = REQ_UP;
         REQ_UP:  if (w_ack_s || w_wd_hit) w_next = REQ_DN;
         REQ_DN:  if (!w_ack_s) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // hs_req is decoded from the next state so the pin comes straight off a flop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_sync      <= '0;
         r_setup_cnt <= 4'd0;
         hs_req      <= 1'b0;
         hs_data     <= '0;
         tx_count    <= 8'd0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], hs_ack};
         r_state <= w_next;
         hs_req  <= (w_next == REQ_UP);
         if (w_accept) begin
            hs_data     <= in_data;
            r_setup_cnt <= SETUP_LOAD;
         end else if (r_state == SETUP && r_setup_cnt != 4'd0) begin
            r_setup_cnt <= r_setup_cnt - 4'd1;
         end
         if (r_state == REQ_DN && w_next == IDLE)
            tx_count <= tx_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_hs4_tx.sv
// Randomized self-checking bench for hs4_tx against a timing/queue reference model.
module tb_hs4_tx;

   localparam int DW    = 8;
   localparam int SETUP = 1;
   localparam int SYNC  = 2;
`ifdef HS4_TX_TIMEOUT_EN
   localparam int TMO = 16;
`else
   localparam int TMO = 255;
`endif
   // Accept edge to return-to-IDLE edge, and accept-to-accept spacing under loopback.
   localparam int DONE   = SETUP + 2*SYNC + 2;
   localparam int PERIOD = DONE + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          hs_req;
   logic [DW-1:0] hs_data;
   logic          hs_ack;
   logic          busy;
   logic [7:0]    tx_count;
   logic          err;

   logic loop_en = 1'b0;
   logic ack_drv = 1'b0;
   assign hs_ack = loop_en ? hs_req : ack_drv;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int mdl_cnt = 0;
   logic [7:0] sendq[$];

   hs4_tx #(.DATA_W(DW), .SETUP_CYC(SETUP), .SYNC_STAGES(SYNC), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .hs_req(hs_req), .hs_data(hs_data), .hs_ack(hs_ack),
      .busy(busy), .tx_count(tx_count), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      loop_en = 1'b0; ack_drv = 1'b0;
      in_valid = 1'b1; in_data = 8'hFF; rst_n = 1'b0;
      repeat (3) tick();
      total++; if (hs_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", hs_req); end
      total++; if (hs_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", hs_data); end
      total++; if (tx_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", tx_count); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
      in_valid = 1'b0;
      rst_n = 1'b1;
      mdl_cnt = 0;
      tick();
   endtask

   task automatic test_single();
      logic exp_req;
      loop_en = 1'b1;
      in_data = 8'hA5; in_valid = 1'b1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_ready0 got=%b exp=1", in_ready); end
      tick();
      in_valid = 1'b0;
      for (int k = 0; k <= DONE + 1; k++) begin
         if (k > 0) tick();
         exp_req = (k >= SETUP) && (k <= SETUP + SYNC);
         total++; if (hs_req !== exp_req) begin bad++; $display("FAIL single_req edge=%0d got=%b exp=%b", k, hs_req, exp_req); end
         total++; if (hs_data !== 8'hA5) begin bad++; $display("FAIL single_data edge=%0d got=%h exp=a5", k, hs_data); end
         total++; if (busy !== (k < DONE)) begin bad++; $display("FAIL single_busy edge=%0d got=%b exp=%b", k, busy, (k < DONE)); end
         if (k == DONE) begin
            total++; if (tx_count !== 8'(mdl_cnt + 1)) begin bad++; $display("FAIL single_count got=%0d exp=%0d", tx_count, mdl_cnt + 1); end
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b exp=1", in_ready); end
         end
      end
      mdl_cnt++;
   endtask

   // Sends every word in sendq with in_valid held; receiver checks data on each hs_req rise.
   task automatic run_stream(input string name);
      logic [7:0] rcvq[$];
      int acc_edges[$];
      int n, last_acc, budget;
      logic prev_req, acc;
      n = sendq.size();
      budget = n * PERIOD + 40;
      last_acc = cyc;
      loop_en = 1'b1;
      in_valid = 1'b1; in_data = sendq[0];
      prev_req = hs_req;
      for (int i = 0; i < budget; i++) begin
         acc = in_valid && in_ready;
         tick();
         if (acc) begin
            acc_edges.push_back(cyc);
            last_acc = cyc;
            rcvq.push_back(sendq.pop_front());
            if (sendq.size() > 0) in_data = sendq[0];
            else in_valid = 1'b0;
         end
         if (!prev_req && hs_req) begin
            total++;
            if (rcvq.size() == 0) begin
               bad++; $display("FAIL %s_rx unexpected request data=%h", name, hs_data);
            end else begin
               if (hs_data !== rcvq[0]) begin bad++; $display("FAIL %s_rx got=%h exp=%h", name, hs_data, rcvq[0]); end
               void'(rcvq.pop_front());
            end
         end
         prev_req = hs_req;
         if (!in_valid && cyc >= last_acc + DONE) break;
      end
      in_valid = 1'b0;
      total++; if (acc_edges.size() != n) begin bad++; $display("FAIL %s_accepts got=%0d exp=%0d", name, acc_edges.size(), n); end
      for (int j = 1; j < acc_edges.size(); j++) begin
         total++;
         if (acc_edges[j] - acc_edges[j-1] != PERIOD) begin
            bad++; $display("FAIL %s_spacing idx=%0d got=%0d exp=%0d", name, j, acc_edges[j] - acc_edges[j-1], PERIOD);
         end
      end
      total++; if (rcvq.size() != 0) begin bad++; $display("FAIL %s_rx_left got=%0d exp=0", name, rcvq.size()); end
      mdl_cnt = (mdl_cnt + n) % 256;
      total++; if (tx_count !== 8'(mdl_cnt)) begin bad++; $display("FAIL %s_count got=%0d exp=%0d", name, tx_count, mdl_cnt); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_ready_end got=%b exp=1", name, in_ready); end
      sendq.delete();
   endtask

   task automatic test_stream_fixed();
      sendq = '{8'h01, 8'h02, 8'h03};
      run_stream("stream3");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++) sendq.push_back(8'($urandom));
      run_stream("b2b");
   endtask

   task automatic test_stuck_ack();
      int errs;
      loop_en = 1'b0; ack_drv = 1'b1; in_valid = 1'b0;
      repeat (SYNC) tick();
      in_valid = 1'b1; in_data = 8'($urandom);
      errs = 0;
      for (int i = 0; i < 20; i++) begin
         if (in_ready !== 1'b0 || busy !== 1'b0) errs++;
         tick();
      end
      total++; if (errs != 0) begin bad++; $display("FAIL stuck_blocked bad_cycles=%0d exp=0", errs); end
      ack_drv = 1'b0;
      for (int k = 1; k <= SYNC; k++) begin
         tick();
         total++;
         if (in_ready !== (k >= SYNC)) begin bad++; $display("FAIL stuck_release k=%0d got=%b exp=%b", k, in_ready, (k >= SYNC)); end
      end
      in_valid = 1'b0;
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL stuck_idle got=%b exp=0", busy); end
   endtask

   task automatic test_reset_mid();
      loop_en = 1'b0; ack_drv = 1'b0;
      in_valid = 1'b1; in_data = 8'($urandom);
      tick();
      in_valid = 1'b0;
      repeat (SETUP + 2) tick();
      total++; if (hs_req !== 1'b1) begin bad++; $display("FAIL rmid_req_up got=%b exp=1", hs_req); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      mdl_cnt = 0;
      total++; if (hs_req !== 1'b0) begin bad++; $display("FAIL rmid_req got=%b exp=0", hs_req); end
      total++; if (tx_count !== 8'd0) begin bad++; $display("FAIL rmid_count got=%0d exp=0", tx_count); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
      sendq.push_back(8'($urandom));
      run_stream("rmid_next");
   endtask

   task automatic test_wrap();
      rst_n = 1'b0; tick(); rst_n = 1'b1; mdl_cnt = 0;
      for (int i = 0; i < 256; i++) sendq.push_back(8'($urandom));
      run_stream("wrap");
   endtask

   task automatic test_timeout();
      loop_en = 1'b0; ack_drv = 1'b0;
      in_valid = 1'b1; in_data = 8'($urandom);
      tick();
      in_valid = 1'b0;
      repeat (SETUP) tick();
      total++; if (hs_req !== 1'b1) begin bad++; $display("FAIL tmo_rise got=%b exp=1", hs_req); end
`ifdef HS4_TX_TIMEOUT_EN
      repeat (TMO - 1) tick();
      total++; if (hs_req !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL tmo_before req=%b err=%b exp req=1 err=0", hs_req, err); end
      tick();
      total++; if (hs_req !== 1'b0) begin bad++; $display("FAIL tmo_req got=%b exp=0", hs_req); end
      total++; if (err !== 1'b1) begin bad++; $display("FAIL tmo_err got=%b exp=1", err); end
      tick();
      total++; if (tx_count !== 8'(mdl_cnt + 1)) begin bad++; $display("FAIL tmo_count got=%0d exp=%0d", tx_count, mdl_cnt + 1); end
      total++; if (err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL tmo_sticky err=%b busy=%b exp err=1 busy=0", err, busy); end
`else
      begin
         int errs;
         errs = 0;
         for (int i = 0; i < 110; i++) begin
            tick();
            if (hs_req !== 1'b1 || err !== 1'b0) errs++;
         end
         total++; if (errs != 0) begin bad++; $display("FAIL tmo_wait bad_cycles=%0d exp=0", errs); end
      end
`endif
      rst_n = 1'b0; tick(); rst_n = 1'b1; mdl_cnt = 0;
      total++; if (err !== 1'b0 || hs_req !== 1'b0) begin bad++; $display("FAIL tmo_clear err=%b req=%b exp 0 0", err, hs_req); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stream_fixed();
      test_back_to_back();
      test_stuck_ack();
      test_reset_mid();
      test_wrap();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
